// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants and shared pixel types
// for the display back-end and the merge stage.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL =
    VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL =
    VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int PIX_W = 24;

  typedef logic [PIX_W-1:0] rgb_t;

  localparam rgb_t VGA_TRANSP_KEY = 24'hFF66CC;
  localparam rgb_t VGA_UFLOW_RGB  = 24'hFF00FF;
  localparam int   VGA_PIPE_LAT   = 2;

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } tim_t;

  localparam tim_t TIM_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1};

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running h/v counters with active and
// sync decode for the current counter position.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic       clk,
  input  logic       rst_n,
  output tim_t       tim,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       origin
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX  = 10'(H_TOT - 1);
  localparam logic [9:0] V_MAX  = 10'(V_TOT - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_last;
  logic       v_last;

  assign h_last = (h_cnt == H_MAX);
  assign v_last = (v_cnt == V_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  always_comb begin
    tim.active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    tim.hs     = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    tim.vs     = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
    x          = h_cnt;
    y          = v_cnt[8:0];
    origin     = (h_cnt == '0) && (v_cnt == '0);
  end

endmodule

// File: rtl/vga_scan_out.sv
// vga_scan_out: issues pixel requests to the merge stage and
// re-aligns returned pixels with delayed sync/enable.
module vga_scan_out
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE      = VGA_H_ACTIVE,
  parameter int   H_FP          = VGA_H_FP,
  parameter int   H_SYNC        = VGA_H_SYNC,
  parameter int   H_BP          = VGA_H_BP,
  parameter int   V_ACTIVE      = VGA_V_ACTIVE,
  parameter int   V_FP          = VGA_V_FP,
  parameter int   V_SYNC        = VGA_V_SYNC,
  parameter int   V_BP          = VGA_V_BP,
  parameter int   PIPE_LAT      = VGA_PIPE_LAT,
  parameter rgb_t UNDERFLOW_RGB = VGA_UFLOW_RGB
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        req_valid,
  output logic [9:0]  req_x,
  output logic [8:0]  req_y,
  output logic        frame_start,
  input  logic [23:0] pix_rgb,
  input  logic        pix_valid,
  output logic [23:0] vga_rgb,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_de,
  output logic        underflow
);

  tim_t       t0;
  logic [9:0] x0;
  logic [8:0] y0;
  logic       org0;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_tim (
    .clk    (clk),
    .rst_n  (rst_n),
    .tim    (t0),
    .x      (x0),
    .y      (y0),
    .origin (org0)
  );

  tim_t req_tim;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_tim     <= TIM_IDLE;
      req_x       <= '0;
      req_y       <= '0;
      frame_start <= 1'b0;
    end else begin
      req_tim     <= t0;
      req_x       <= t0.active ? x0 : '0;
      req_y       <= t0.active ? y0 : '0;
      frame_start <= t0.active && org0;
    end
  end

  assign req_valid = req_tim.active;

  // dl[PIPE_LAT-1] lines up with the pixel returned for a request
  tim_t dl [PIPE_LAT];
  tim_t late;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++) dl[i] <= TIM_IDLE;
    end else begin
      dl[0] <= req_tim;
      for (int i = 1; i < PIPE_LAT; i++) dl[i] <= dl[i-1];
    end
  end

  assign late = dl[PIPE_LAT-1];

  rgb_t rgb_d;
  logic uf_d;

  always_comb begin
    rgb_d = '0;
    uf_d  = 1'b0;
    unique case (1'b1)
      !late.active: rgb_d = '0;
      late.active && pix_valid: rgb_d = pix_rgb;
      late.active && !pix_valid: begin
        rgb_d = UNDERFLOW_RGB;
        uf_d  = 1'b1;
      end
      default: rgb_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_rgb   <= '0;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
      vga_de    <= 1'b0;
      underflow <= 1'b0;
    end else begin
      vga_rgb   <= rgb_d;
      vga_hsync <= late.hs;
      vga_vsync <= late.vs;
      vga_de    <= late.active;
      underflow <= underflow | uf_d;
    end
  end

endmodule
